shift_ctrl: RTL and testbench
=============================

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
- Parameters: none; datapath fixed at 32 bits, rotator amount fixed at 5 bits.
- REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
- REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
- REQ-003 SHALL have port: in_valid  in  1  shift request present.
- REQ-004 SHALL have port: in_ready  out  1  controller can accept a request.
- REQ-005 SHALL have port: op  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101-111 illegal.
- REQ-006 SHALL have port: amt  in  8  shift amount n, Rs[7:0] semantics.
- REQ-007 SHALL have port: data  in  32  operand.
- REQ-008 SHALL have port: c_in  in  1  current CPSR C flag.
- REQ-009 SHALL have port: bs_data  out  32  operand to external barrel_shifter rotator.
- REQ-010 SHALL have port: bs_amt  out  5  rotate amount to rotator.
- REQ-011 SHALL have port: bs_dir  out  1  rotator direction, 1 = left, 0 = right.
- REQ-012 SHALL have port: bs_out  in  32  rotated value returned combinationally by rotator.
- REQ-013 SHALL have port: out_valid  out  1  result available.
- REQ-014 SHALL have port: out_ready  in  1  consumer accepts result.
- REQ-015 SHALL have port: result  out  32  shifted operand.
- REQ-016 SHALL have port: c_out  out  1  shifter carry-out.

Function
- REQ-017 SHALL implement FSM IDLE -> ROT -> FIX -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
- REQ-018 SHALL capture op/amt/data/c_in into registers and go IDLE->ROT on the edge where in_valid & in_ready; inputs ignored otherwise.
- REQ-019 In ROT, SHALL drive bs_data = captured data; bs_dir=1, bs_amt=n[4:0] for LSL; bs_dir=0, bs_amt=n[4:0] for LSR/ASR/ROR; bs_dir=0, bs_amt=1 for RRX; bs_* SHALL be 0 in all other states.
- REQ-020 SHALL register bs_out on ROT->FIX edge; FIX computes result/c_out (masking, sign fill, carry) and registers them on FIX->DONE edge; out_valid thus rises 3 cycles after accept.
- REQ-021 SHALL hold result, c_out, out_valid stable in DONE until out_ready=1; DONE->IDLE on that edge; result/c_out retain value after leaving DONE.
- REQ-022 Sustained throughput SHALL be one request per 4 cycles with out_ready tied high.
- REQ-023 Any op with n=0 (except RRX) SHALL give result=data, c_out=c_in.
- REQ-024 LSL: n 1..31 -> data<<n, c=data[32-n]; n=32 -> 0, c=data[0]; n>32 -> 0, c=0.
- REQ-025 LSR: n 1..31 -> data>>n, c=data[n-1]; n=32 -> 0, c=data[31]; n>32 -> 0, c=0.
- REQ-026 ASR: n 1..31 -> arithmetic shift, c=data[n-1]; n>=32 -> 32 copies of data[31], c=data[31].
- REQ-027 ROR: n[4:0]!=0 -> rotate right n[4:0], c=result[31]; n!=0 with n[4:0]=0 -> data, c=data[31].
- REQ-028 RRX: result={c_in,data[31:1]}, c=data[0]; amt ignored.
- REQ-029 Illegal op SHALL give result=data, c_out=c_in, same latency.

Reset
- REQ-030 rst_n low SHALL force state IDLE immediately: in_ready=1, out_valid=0, result=0, c_out=0, bs_*=0, capture registers 0.
- REQ-031 Reset in ROT/FIX/DONE SHALL abandon the transaction; no out_valid for it after release.
- REQ-032 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
- REQ-033 LSL data=0x80000001 n=1 c_in=0 -> result 0x00000002, c_out 1, out_valid 3 cycles after accept.
- REQ-034 LSR data=0x80000000: n=32 -> 0x0, c 1; n=33 -> 0x0, c 0; n=0 c_in=1 -> 0x80000000, c 1.
- REQ-035 ASR data=0x80000000: n=4 -> 0xF8000000, c 0; n=40 -> 0xFFFFFFFF, c 1.
- REQ-036 ROR data=0x00000001: n=1 -> 0x80000000, c 1; n=32 -> 0x00000001, c 0; RRX data=0x3 c_in=1 -> 0x80000001, c 1.
- REQ-037 out_ready low 5 cycles in DONE -> result/out_valid held, in_ready 0, next request accepted only after release.
- REQ-038 rst_n pulsed low during ROT -> out_valid stays 0, in_ready 1 during reset, new request after release completes correctly.

Source files
------------

// File: rtl/shift_ctrl.sv
// Shift controller: captures a shift request, drives an external rotator, then
// masks / sign-fills the rotated value and computes the ARM-style carry-out.
module shift_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [7:0]  amt,
    input  logic [31:0] data,
    input  logic        c_in,
    output logic [31:0] bs_data,
    output logic [4:0]  bs_amt,
    output logic        bs_dir,
    input  logic [31:0] bs_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        c_out
);

    typedef enum logic [1:0] {IDLE, ROT, FIX, DONE} state_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_RRX = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  amt_q, amt_d;
    logic [31:0] data_q, data_d;
    logic        c_in_q, c_in_d;
    logic [31:0] rot_q, rot_d;
    logic [31:0] result_q, result_d;
    logic        c_out_q, c_out_d;

    logic [4:0]  n5;
    logic        n_zero;
    logic        n_small;
    logic        n_is32;
    logic [31:0] lo_mask;
    logic [31:0] hi_mask;
    logic [4:0]  lsl_idx;
    logic [4:0]  rsh_idx;
    logic [31:0] fix_res;
    logic        fix_c;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign c_out     = c_out_q;

    always_comb begin
        bs_data = 32'd0;
        bs_amt  = 5'd0;
        bs_dir  = 1'b0;
        if (state_q == ROT) begin
            bs_data = data_q;
            case (op_q)
                OP_LSL: begin
                    bs_dir = 1'b1;
                    bs_amt = amt_q[4:0];
                end
                OP_LSR, OP_ASR, OP_ROR: bs_amt = amt_q[4:0];
                OP_RRX: bs_amt = 5'd1;
                default: bs_amt = 5'd0;
            endcase
        end
    end

    // Amount decode shared by the fix-up stage; n >= 32 is any of amt[7:5] set.
    assign n5      = amt_q[4:0];
    assign n_zero  = (amt_q == 8'd0);
    assign n_small = (amt_q[7:5] == 3'd0);
    assign n_is32  = (amt_q == 8'd32);
    assign lo_mask = 32'hFFFF_FFFF >> n5;
    assign hi_mask = 32'hFFFF_FFFF << n5;
    assign lsl_idx = 5'(6'd32 - {1'b0, n5});
    assign rsh_idx = n5 - 5'd1;

    always_comb begin
        fix_res = data_q;
        fix_c   = c_in_q;
        case (op_q)
            OP_LSL: begin
                if (!n_zero) begin
                    if (n_small) begin
                        fix_res = rot_q & hi_mask;
                        fix_c   = data_q[lsl_idx];
                    end else begin
                        fix_res = 32'd0;
                        fix_c   = n_is32 ? data_q[0] : 1'b0;
                    end
                end
            end
            OP_LSR: begin
                if (!n_zero) begin
                    if (n_small) begin
                        fix_res = rot_q & lo_mask;
                        fix_c   = data_q[rsh_idx];
                    end else begin
                        fix_res = 32'd0;
                        fix_c   = n_is32 ? data_q[31] : 1'b0;
                    end
                end
            end
            OP_ASR: begin
                if (!n_zero) begin
                    if (n_small) begin
                        fix_res = (rot_q & lo_mask) | ({32{data_q[31]}} & ~lo_mask);
                        fix_c   = data_q[rsh_idx];
                    end else begin
                        fix_res = {32{data_q[31]}};
                        fix_c   = data_q[31];
                    end
                end
            end
            OP_ROR: begin
                // With n[4:0]==0 the rotator returns data unchanged, so one rule covers both cases.
                if (!n_zero) begin
                    fix_res = rot_q;
                    fix_c   = rot_q[31];
                end
            end
            OP_RRX: begin
                fix_res = {c_in_q, rot_q[30:0]};
                fix_c   = data_q[0];
            end
            default: begin
                fix_res = data_q;
                fix_c   = c_in_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        amt_d    = amt_q;
        data_d   = data_q;
        c_in_d   = c_in_q;
        rot_d    = rot_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    amt_d   = amt;
                    data_d  = data;
                    c_in_d  = c_in;
                    state_d = ROT;
                end
            end
            ROT: begin
                rot_d   = bs_out;
                state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                c_out_d  = fix_c;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            amt_q    <= 8'd0;
            data_q   <= 32'd0;
            c_in_q   <= 1'b0;
            rot_q    <= 32'd0;
            result_q <= 32'd0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            amt_q    <= amt_d;
            data_q   <= data_d;
            c_in_q   <= c_in_d;
            rot_q    <= rot_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: models the external rotator, keeps a reference shifter
// and transaction-age model, and checks every cycle plus directed literal vectors.
module tb_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [7:0]  amt = 8'd0;
    logic [31:0] data = 32'd0;
    logic        c_in = 1'b0;
    logic [31:0] bs_data;
    logic [4:0]  bs_amt;
    logic        bs_dir;
    logic [31:0] bs_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        c_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_accept = 0;
    bit run_chk = 1'b0;

    shift_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .amt(amt), .data(data), .c_in(c_in),
        .bs_data(bs_data), .bs_amt(bs_amt), .bs_dir(bs_dir), .bs_out(bs_out),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .c_out(c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External rotator
    always_comb begin
        if (bs_amt == 5'd0) bs_out = bs_data;
        else if (bs_dir) bs_out = (bs_data << bs_amt) | (bs_data >> (6'd32 - {1'b0, bs_amt}));
        else bs_out = (bs_data >> bs_amt) | (bs_data << (6'd32 - {1'b0, bs_amt}));
    end

    // Reference shifter straight from the shift rules; returns {carry, result}.
    function automatic logic [32:0] ref_shift(input logic [2:0] f_op, input logic [7:0] f_amt,
                                              input logic [31:0] d, input logic ci);
        int n;
        int r;
        logic [31:0] v;
        n = int'(f_amt);
        r = n % 32;
        case (f_op)
            3'd0: begin
                if (n == 0) return {ci, d};
                else if (n < 32) return {d[32-n], d << n};
                else if (n == 32) return {d[0], 32'd0};
                else return 33'd0;
            end
            3'd1: begin
                if (n == 0) return {ci, d};
                else if (n < 32) return {d[n-1], d >> n};
                else if (n == 32) return {d[31], 32'd0};
                else return 33'd0;
            end
            3'd2: begin
                if (n == 0) return {ci, d};
                else if (n < 32) begin
                    v = $unsigned($signed(d) >>> n);
                    return {d[n-1], v};
                end else return {d[31], {32{d[31]}}};
            end
            3'd3: begin
                if (n == 0) return {ci, d};
                else if (r == 0) return {d[31], d};
                else begin
                    v = (d >> r) | (d << (32 - r));
                    return {v[31], v};
                end
            end
            3'd4: return {d[0], ci, d[31:1]};
            default: return {ci, d};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=0x%08h expected=0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction model: age 0 idle, 1..3 = cycles since accept (3 = result held).
    int          age = 0;
    logic [2:0]  m_op = 3'd0;
    logic [7:0]  m_amt = 8'd0;
    logic [31:0] m_data = 32'd0;
    logic [32:0] m_exp = 33'd0;
    logic [31:0] last_res = 32'd0;
    logic        last_c = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age      <= 0;
            last_res <= 32'd0;
            last_c   <= 1'b0;
        end else begin
            if (age == 0) begin
                if (in_valid) begin
                    age    <= 1;
                    m_op   <= op;
                    m_amt  <= amt;
                    m_data <= data;
                    m_exp  <= ref_shift(op, amt, data, c_in);
                end
            end else if (age == 3) begin
                if (out_ready) age <= 0;
            end else begin
                if (age == 2) begin
                    last_res <= m_exp[31:0];
                    last_c   <= m_exp[32];
                end
                age <= age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            check("in_ready", 32'(in_ready), 32'(age == 0));
            check("out_valid", 32'(out_valid), 32'(age == 3));
            check("result", result, last_res);
            check("c_out", 32'(c_out), 32'(last_c));
            if (age == 1) begin
                if (m_op <= 3'd4) begin
                    check("bs_data", bs_data, m_data);
                    check("bs_dir", 32'(bs_dir), 32'(m_op == 3'd0));
                    check("bs_amt", 32'(bs_amt), (m_op == 3'd4) ? 32'd1 : 32'(m_amt % 32));
                end
            end else begin
                check("bs_idle", {bs_data[31:6], bs_dir, bs_amt}, 32'd0);
            end
        end
    end

    task automatic run(input logic [2:0] op_i, input logic [7:0] amt_i, input logic [31:0] d_i,
                       input logic c_i, input logic [31:0] er, input logic ec,
                       input int hold, input bit tp);
        int lat;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout op=%0d amt=%0d", op_i, amt_i);
            return;
        end
        if (tp) check("throughput", 32'(cyc - prev_accept), 32'd4);
        prev_accept = cyc;
        in_valid  = 1'b1;
        op        = op_i;
        amt       = amt_i;
        data      = d_i;
        c_in      = c_i;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'd0; amt = 8'd0; data = 32'hDEAD_BEEF; c_in = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("vec_result", result, er);
        check("vec_c_out", 32'(c_out), 32'(ec));
        $display("txn op=%0d amt=%0d data=0x%08h c_in=%0b -> result=0x%08h c_out=%0b",
                 op_i, amt_i, d_i, c_i, result, c_out);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_result", result, er);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        run_chk = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(3'd0, 8'd1,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 0, 1'b0);
        run(3'd1, 8'd32, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 0, 1'b1);
        run(3'd1, 8'd33, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 0, 1'b1);
        run(3'd1, 8'd0,  32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 0, 1'b1);
        run(3'd2, 8'd4,  32'h8000_0000, 1'b0, 32'hF800_0000, 1'b0, 0, 1'b1);
        run(3'd2, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
        run(3'd3, 8'd1,  32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 0, 1'b1);
        run(3'd3, 8'd32, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 0, 1'b1);
        run(3'd4, 8'd7,  32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 0, 1'b1);
        run(3'd5, 8'd3,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0, 1'b1);
        run(3'd0, 8'd4,  32'h0000_000F, 1'b0, 32'h0000_00F0, 1'b0, 0, 1'b1);
        run(3'd0, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0, 1'b1);
        run(3'd0, 8'd33, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 0, 1'b1);
        run(3'd2, 8'd5,  32'h7FFF_FFF0, 1'b0, 32'h03FF_FFFF, 1'b1, 0, 1'b1);
        run(3'd1, 8'd5,  32'h0000_00F0, 1'b0, 32'h0000_0007, 1'b1, 0, 1'b1);
        run(3'd3, 8'h40, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 0, 1'b1);
        run(3'd3, 8'd4,  32'h0000_00F0, 1'b1, 32'h0000_000F, 1'b0, 5, 1'b1);
        run(3'd7, 8'd0,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

        // Reset while the rotator stage is active abandons the request.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; amt = 8'd8; data = 32'h0000_00AB; c_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_in_rot", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        run(3'd1, 8'd4,  32'h0000_0F00, 1'b0, 32'h0000_00F0, 1'b0, 0, 1'b0);
        run(3'd0, 8'd31, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1, 0, 1'b1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
